poly_loader: RTL and testbench
==============================

POLY_LOADER -- requirements
Module: poly_loader

Interface
REQ-001 SHALL have parameter Q, default 8380417, the Dilithium modulus used for input reduction.
REQ-002 SHALL have parameter NUM_WORDS, default 64, the number of 96-bit BRAM words per polynomial (4 coefficients per word).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  the synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  a one-cycle request to begin loading one polynomial.
REQ-006 SHALL have port busy  output  1  high from the cycle after an accepted start until the cycle done is asserted, inclusive.
REQ-007 SHALL have port done  output  1  a one-cycle completion pulse.
REQ-008 SHALL have port s_valid  input  1  upstream coefficient valid.
REQ-009 SHALL have port s_data  input  24  upstream coefficient, unsigned.
REQ-010 SHALL have port s_ready  output  1  loader can accept a coefficient this cycle.
REQ-011 SHALL have port addrb  output  6  BRAM write address.
REQ-012 SHALL have port web  output  1  BRAM write enable.
REQ-013 SHALL have port dib  output  96  BRAM write data.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, FLUSH, DONE.
REQ-015 SHALL transition IDLE->LOAD on start=1; start in any other state is ignored.
REQ-016 SHALL clear the coefficient counter (8 bits: lane = bits[1:0], word = bits[7:2]) on entry to LOAD.
REQ-017 SHALL assert s_ready=1 only in LOAD; s_ready is 0 in IDLE, FLUSH and DONE.
REQ-018 SHALL accept a coefficient on every cycle with s_valid=1 and s_ready=1 (transfer); s_data is ignored otherwise.
REQ-019 SHALL reduce each transferred coefficient as c' = (c >= Q) ? c - Q : c (single conditional subtract); inputs >= 2Q are out of contract, and the loader SHALL still write c - Q truncated to 24 bits without stalling.
REQ-020 SHALL place the reduced coefficient with lane index j in dib bits [24j+23:24j], so word k holds coefficients 4k..4k+3 in natural order.
REQ-021 SHALL, on the transfer with lane=3, register web=1, addrb=word, and dib={c'3,c'2,c'1,c'0} for exactly the next cycle.
REQ-022 SHALL sustain one transfer per cycle while s_valid stays high: 256 coefficients take 256 LOAD cycles, and no bubble is inserted at a write.
REQ-023 SHALL hold the lane register contents unchanged across cycles without a transfer; gaps in s_valid do not corrupt partial words.
REQ-024 SHALL transition LOAD->FLUSH on the transfer of coefficient 4*NUM_WORDS-1 (counter 255); s_ready is 0 from the next cycle.
REQ-025 SHALL have the final write (addrb=NUM_WORDS-1, web=1) occur in the FLUSH cycle, then move FLUSH->DONE.
REQ-026 SHALL assert done=1 for exactly the DONE cycle, then return DONE->IDLE; with that cycle aligned to transfer 255 at cycle T, the last web is at T+1 and done is at T+2.
REQ-027 SHALL drive web=0 in every cycle not selected by REQ-021; addrb and dib keep their last values when web=0.
REQ-028 SHALL accept a start that arrives in the same cycle as done, entering LOAD on the following cycle.

Reset
REQ-029 SHALL, on rst=1, force state IDLE, counter 0, lane registers 0, busy=0, done=0, s_ready=0, web=0, addrb=0, dib=0 in the next cycle.
REQ-030 SHALL give rst priority over start and s_valid in the same cycle.
REQ-031 SHALL, on rst mid-LOAD, abort without any further write; a partially filled word is discarded.

Verification
REQ-032 Full-rate load: start, then s_valid=1 with s_data=i for i=0..255 -> 64 writes with addrb=k and dib={4k+3,4k+2,4k+1,4k}, done 2 cycles after the last transfer, busy low after done.
REQ-033 Reduction: s_data=8380417, 8380418, 8380416, 0 as word 0 -> dib={0,8380416,1,0}.
REQ-034 Back-pressure gaps: s_valid toggling randomly over 256 coefficients -> identical BRAM contents to REQ-032, with web pulses only after each 4th transfer.
REQ-035 Reset mid-load: rst after 130 transfers -> web never asserts again, s_ready=0, done never pulses; a subsequent full load produces correct contents.
REQ-036 Ignored start: start pulsed during LOAD -> counter is not cleared and addrb sequence stays 0..63 monotonic.
REQ-037 Back-to-back: start coincident with done -> second load begins in LOAD the next cycle and completes correctly.

Source files
------------

// File: rtl/poly_loader.sv
// poly_loader: reduces a stream of 24-bit coefficients mod Q and packs them four per 96-bit BRAM word
module poly_loader #(
  parameter int Q = 8380417,
  parameter int NUM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        s_valid,
  input  logic [23:0] s_data,
  output logic        s_ready,
  output logic [5:0]  addrb,
  output logic        web,
  output logic [95:0] dib
);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  localparam logic [7:0] LAST = 8'(4 * NUM_WORDS - 1);
  localparam logic [23:0] QW = 24'(Q);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0][23:0] lane_q, lane_d;
  logic web_q, web_d;
  logic [5:0] addrb_q, addrb_d;
  logic [95:0] dib_q, dib_d;
  logic xfer;
  logic [23:0] red;
  always_comb begin
    xfer = state_q == LOAD && s_valid;
    red = s_data >= QW ? s_data - QW : s_data;
    state_d = state_q;
    cnt_d = cnt_q;
    lane_d = lane_q;
    web_d = 1'b0;
    addrb_d = addrb_q;
    dib_d = dib_q;
    if (start && (state_q == IDLE || state_q == DONE)) begin
      state_d = LOAD;
      cnt_d = '0;
    end else if (state_q == FLUSH) state_d = DONE;
    else if (state_q == DONE) state_d = IDLE;
    // lanes shift down so coefficient 0 of a word ends up in the low slot
    if (xfer) begin
      cnt_d = cnt_q + 8'd1;
      lane_d = {red, lane_q[2:1]};
      web_d = cnt_q[1:0] == 2'd3;
      addrb_d = web_d ? cnt_q[7:2] : addrb_q;
      dib_d = web_d ? {red, lane_q} : dib_q;
      if (cnt_q == LAST) state_d = FLUSH;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      lane_q <= '0;
      web_q <= 1'b0;
      addrb_q <= '0;
      dib_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lane_q <= lane_d;
      web_q <= web_d;
      addrb_q <= addrb_d;
      dib_q <= dib_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign s_ready = state_q == LOAD;
  assign web = web_q;
  assign addrb = addrb_q;
  assign dib = dib_q;
endmodule

// File: tb/tb_poly_loader.sv
// tb_poly_loader: directed sequence with random data/gaps checked against a word-level reference model
module tb_poly_loader;
  localparam int Q = 8380417;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, s_valid = 1'b0;
  logic [23:0] s_data = '0;
  logic busy, done, s_ready, web;
  logic [5:0] addrb;
  logic [95:0] dib;
  int checks = 0, failures = 0, cyc = 0;
  logic [23:0] d [256];
  logic [95:0] mem [64];
  int wr_addr [$], wr_cyc [$], done_cyc [$], xcyc [$];

  poly_loader #(.Q(Q), .NUM_WORDS(64)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .addrb(addrb), .web(web), .dib(dib)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (web) begin
      mem[addrb] = dib;
      wr_addr.push_back(int'(addrb));
      wr_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
  end

  function automatic logic [23:0] reduce(input logic [23:0] c);
    return (int'(c) >= Q) ? 24'(int'(c) - Q) : c;
  endfunction

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr.delete(); wr_cyc.delete(); done_cyc.delete(); xcyc.delete();
    foreach (mem[k]) mem[k] = 'x;
  endtask

  task automatic fill(input bit seq);
    for (int i = 0; i < 256; i++) d[i] = seq ? 24'(i) : 24'($urandom);
  endtask

  task automatic feed(input int n, input bit gaps, input int ign);
    int i = 0, g = 0;
    while (i < n && g < 4000) begin
      @(negedge clk);
      g++;
      start = (ign >= 0 && i == ign);
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data = s_valid ? d[i] : 24'($urandom);
      if (s_valid && s_ready) begin
        xcyc.push_back(cyc);
        i++;
      end
    end
    chk("feed_timeout", 96'(i), 96'(n));
  endtask

  task automatic wait_done();
    int g = 0;
    do begin
      @(negedge clk);
      s_valid = 1'b0;
      start = 1'b0;
      g++;
    end while (!done && g < 10);
    chk("done_seen", 96'(done), 96'(1));
    chk("busy_at_done", 96'(busy), 96'(1));
  endtask

  task automatic check_load(input string tag);
    int bad_addr = 0, bad_cyc = 0;
    logic [95:0] e;
    chk({tag, "_nwrites"}, 96'(wr_addr.size()), 96'(64));
    for (int k = 0; k < 64; k++) begin
      e = {reduce(d[4*k+3]), reduce(d[4*k+2]), reduce(d[4*k+1]), reduce(d[4*k])};
      chk($sformatf("%s_word%0d", tag, k), mem[k], e);
    end
    for (int k = 0; k < wr_addr.size() && k < 64; k++) begin
      if (wr_addr[k] != k) bad_addr++;
      if (xcyc.size() == 256 && wr_cyc[k] != xcyc[4*k+3] + 1) bad_cyc++;
    end
    chk({tag, "_addr_seq"}, 96'(bad_addr), 96'(0));
    chk({tag, "_write_timing"}, 96'(bad_cyc), 96'(0));
    chk({tag, "_ndone"}, 96'(done_cyc.size()), 96'(1));
    if (done_cyc.size() == 1 && xcyc.size() == 256)
      chk({tag, "_done_cyc"}, 96'(done_cyc[0]), 96'(xcyc[255] + 2));
  endtask

  task automatic run_load(input string tag, input bit gaps, input int ign);
    clear_logs();
    @(negedge clk);
    start = 1'b1;
    feed(256, gaps, ign);
    wait_done();
    check_load(tag);
    @(negedge clk);
    chk({tag, "_busy_after"}, 96'(busy), 96'(0));
    chk({tag, "_done_after"}, 96'(done), 96'(0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_done", 96'(done), 96'(0));
    chk("rst_ready", 96'(s_ready), 96'(0));
    chk("rst_web", 96'(web), 96'(0));
    chk("rst_addrb", 96'(addrb), 96'(0));
    chk("rst_dib", dib, 96'(0));
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; start = 1'b1; s_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; s_valid = 1'b0;
    chk("rst_prio_ready", 96'(s_ready), 96'(0));
    chk("rst_prio_busy", 96'(busy), 96'(0));

    fill(1'b1);
    run_load("full", 1'b0, -1);

    fill(1'b0);
    d[0] = 24'(Q); d[1] = 24'(Q + 1); d[2] = 24'(Q - 1); d[3] = 24'd0;
    run_load("reduce", 1'b0, -1);
    chk("reduce_word0_const", mem[0], {24'd0, 24'(Q - 1), 24'd1, 24'd0});

    fill(1'b1);
    run_load("gaps", 1'b1, -1);

    fill(1'b0);
    run_load("ign_start", 1'b1, 50);

    fill(1'b0);
    clear_logs();
    @(negedge clk);
    start = 1'b1;
    feed(130, 1'b0, -1);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; s_valid = 1'b1; s_data = d[130];
    @(negedge clk);
    rst = 1'b0; start = 1'b0; s_valid = 1'b0;
    chk("midrst_ready", 96'(s_ready), 96'(0));
    chk("midrst_busy", 96'(busy), 96'(0));
    chk("midrst_web", 96'(web), 96'(0));
    chk("midrst_dib", dib, 96'(0));
    chk("midrst_addrb", 96'(addrb), 96'(0));
    repeat (10) @(negedge clk);
    chk("midrst_nwrites", 96'(wr_addr.size()), 96'(32));
    chk("midrst_ndone", 96'(done_cyc.size()), 96'(0));
    fill(1'b0);
    run_load("after_rst", 1'b0, -1);

    fill(1'b0);
    clear_logs();
    @(negedge clk);
    start = 1'b1;
    feed(256, 1'b0, -1);
    wait_done();
    check_load("b2b_first");
    clear_logs();
    fill(1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_ready_next", 96'(s_ready), 96'(1));
    feed(256, 1'b1, -1);
    wait_done();
    check_load("b2b_second");
    @(negedge clk);
    chk("b2b_busy_after", 96'(busy), 96'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
